// File: rtl/row_feeder_buffer.sv
// Row-oriented FIFO feeding the PE array: buffers upstream words and hands
// out whole rows through the controller's data_rdy/read_en handshake.
module row_feeder_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 32,
  parameter int ROW_WORDS  = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         s_valid_i,
  input  logic [DATA_WIDTH-1:0]        s_data_i,
  output logic                         s_ready_o,
  input  logic                         flush_i,
  output logic                         data_rdy_o,
  input  logic                         read_en_i,
  output logic [DATA_WIDTH-1:0]        data_o,
  output logic                         data_vld_o,
  output logic                         row_done_o,
  output logic                         underflow_o,
  output logic [$clog2(DEPTH+1)-1:0]   level_o
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int RCW = $clog2(ROW_WORDS + 1);

  localparam logic [CW-1:0]  DEPTH_CNT = CW'(DEPTH);
  localparam logic [CW-1:0]  ROW_CNT   = CW'(ROW_WORDS);
  localparam logic [RCW-1:0] LAST_CNT  = RCW'(ROW_WORDS - 1);

  typedef enum logic [1:0] {S_WAIT, S_RDY, S_BURST} state_t;

  state_t                  state;
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic [CW-1:0]           count;
  logic [CW-1:0]           count_next;
  logic [RCW-1:0]          rd_cnt;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic wr_fire;
  logic rd_fire;
  logic row_end;

  assign s_ready_o  = (count != DEPTH_CNT);
  assign data_rdy_o = (state != S_WAIT);
  assign level_o    = count;

  assign wr_fire = s_valid_i & s_ready_o;
  assign rd_fire = read_en_i & (state != S_WAIT);

  // A single-word row completes on the arming pop itself.
  assign row_end = rd_fire &
                   (((state == S_BURST) && (rd_cnt == LAST_CNT)) ||
                    ((state == S_RDY) && (ROW_WORDS == 1)));

  always_comb begin
    count_next = count;
    if (wr_fire && !rd_fire)      count_next = count + CW'(1);
    else if (rd_fire && !wr_fire) count_next = count - CW'(1);
  end

  // NOTE: storage has no reset; the pointers and count alone define which
  // entries are valid, so clearing the array would only cost logic.
  always_ff @(posedge clk) begin
    if (rst_n && !flush_i && wr_fire) mem[wr_ptr] <= s_data_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_WAIT;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      rd_cnt      <= '0;
      data_o      <= '0;
      data_vld_o  <= 1'b0;
      row_done_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else if (flush_i) begin
      // Same as reset except the last delivered word stays on data_o.
      state       <= S_WAIT;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      rd_cnt      <= '0;
      data_vld_o  <= 1'b0;
      row_done_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + AW'(1);
      if (rd_fire) begin
        data_o <= mem[rd_ptr];
        rd_ptr <= rd_ptr + AW'(1);
      end
      data_vld_o <= rd_fire;
      row_done_o <= row_end;
      count      <= count_next;
      if ((state == S_WAIT) && read_en_i) underflow_o <= 1'b1;

      case (state)
        S_WAIT: begin
          if (count >= ROW_CNT) state <= S_RDY;
        end
        S_RDY, S_BURST: begin
          if (rd_fire) begin
            if (row_end) begin
              rd_cnt <= '0;
              state  <= (count_next >= ROW_CNT) ? S_RDY : S_WAIT;
            end else begin
              // rd_cnt is zero in RDY, so this also arms the first pop.
              rd_cnt <= rd_cnt + RCW'(1);
              state  <= S_BURST;
            end
          end
        end
        default: state <= S_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_row_feeder_buffer.sv
// Directed bench for row_feeder_buffer: arming, bursts, stalls with wrap,
// backpressure, flush priority, sticky underflow and reset mid-burst.
module tb_row_feeder_buffer;

  localparam int DATA_WIDTH = 16;
  localparam int DEPTH      = 32;
  localparam int ROW_WORDS  = 16;
  localparam int LW         = $clog2(DEPTH + 1);

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  s_valid_i;
  logic [DATA_WIDTH-1:0] s_data_i;
  logic                  s_ready_o;
  logic                  flush_i;
  logic                  data_rdy_o;
  logic                  read_en_i;
  logic [DATA_WIDTH-1:0] data_o;
  logic                  data_vld_o;
  logic                  row_done_o;
  logic                  underflow_o;
  logic [LW-1:0]         level_o;

  int pass_cnt  = 0;
  int total_cnt = 0;

  row_feeder_buffer #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH(DEPTH),
    .ROW_WORDS(ROW_WORDS)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .s_valid_i(s_valid_i),
    .s_data_i(s_data_i),
    .s_ready_o(s_ready_o),
    .flush_i(flush_i),
    .data_rdy_o(data_rdy_o),
    .read_en_i(read_en_i),
    .data_o(data_o),
    .data_vld_o(data_vld_o),
    .row_done_o(row_done_o),
    .underflow_o(underflow_o),
    .level_o(level_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    else pass_cnt++;
  endtask

  // Apply inputs for one clock edge, then sample 1 time unit after it.
  task automatic drive(input logic v, input logic [15:0] d, input logic re, input logic fl);
    s_valid_i = v;
    s_data_i  = d;
    read_en_i = re;
    flush_i   = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic push_words(input logic [15:0] base, input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 16'(base + i), 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    check("rst_data", data_o, 0);
    check("rst_vld", data_vld_o, 0);
    check("rst_done", row_done_o, 0);
    check("rst_uf", underflow_o, 0);
    check("rst_level", level_o, 0);
    check("rst_ready", s_ready_o, 1);
    check("rst_rdy", data_rdy_o, 0);
    rst_n = 1'b1;

    // Fill to arm
    push_words(16'h0001, 15);
    check("fill15_level", level_o, 15);
    check("fill15_rdy", data_rdy_o, 0);
    drive(1'b1, 16'h0010, 1'b0, 1'b0);
    check("fill16_level", level_o, 16);
    check("fill16_rdy_edge", data_rdy_o, 0);
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    check("fill16_rdy", data_rdy_o, 1);

    // Row burst
    for (int k = 1; k <= 16; k++) begin
      drive(1'b0, 16'h0, 1'b1, 1'b0);
      check("burst_data", data_o, k);
      check("burst_vld", data_vld_o, 1);
      check("burst_done", row_done_o, k == 16);
      check("burst_rdy", data_rdy_o, k < 16);
    end
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    check("post_burst_vld", data_vld_o, 0);
    check("post_burst_done", row_done_o, 0);
    check("post_burst_level", level_o, 0);
    check("post_burst_hold", data_o, 16'h0010);

    // Stalled burst with concurrent writes; pointers start at 16 and wrap
    push_words(16'h0300, 20);
    check("st_level20", level_o, 20);
    check("st_rdy", data_rdy_o, 1);
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 16'h0, 1'b1, 1'b0);
      check("st_pop5_data", data_o, 16'h0300 + k);
      check("st_pop5_vld", data_vld_o, 1);
    end
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 16'h0, 1'b0, 1'b0);
      check("st_idle_vld", data_vld_o, 0);
      check("st_idle_rdy", data_rdy_o, 1);
      check("st_idle_level", level_o, 15);
    end
    drive(1'b1, 16'h0400, 1'b0, 1'b0);
    check("st_idle3_level", level_o, 16);
    check("st_idle3_vld", data_vld_o, 0);
    for (int j = 1; j <= 11; j++) begin
      drive(1'b1, 16'(16'h0400 + j), 1'b1, 1'b0);
      check("st_pop11_data", data_o, 16'h0305 + j - 1);
      check("st_pop11_vld", data_vld_o, 1);
      check("st_pop11_done", row_done_o, j == 11);
      check("st_pop11_level", level_o, 16);
    end
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    check("st_rearm_rdy", data_rdy_o, 1);
    check("st_rearm_done", row_done_o, 0);
    for (int k = 0; k < 16; k++) begin
      drive(1'b0, 16'h0, 1'b1, 1'b0);
      check("wrap_data", data_o, (k < 4) ? 16'h0310 + k : 16'h0400 + k - 4);
      check("wrap_done", row_done_o, k == 15);
    end
    check("wrap_rdy", data_rdy_o, 0);
    check("wrap_level", level_o, 0);

    // Full / backpressure: 32 accepted, 33rd (0x01FF) waits for a pop
    push_words(16'h0100, 32);
    check("full_level", level_o, 32);
    check("full_ready", s_ready_o, 0);
    drive(1'b1, 16'h01FF, 1'b0, 1'b0);
    drive(1'b1, 16'h01FF, 1'b0, 1'b0);
    check("full_hold_level", level_o, 32);
    check("full_hold_ready", s_ready_o, 0);
    drive(1'b1, 16'h01FF, 1'b1, 1'b0);
    check("full_pop_data", data_o, 16'h0100);
    check("full_pop_vld", data_vld_o, 1);
    check("full_pop_level", level_o, 31);
    check("full_pop_ready", s_ready_o, 1);
    drive(1'b1, 16'h01FF, 1'b0, 1'b0);
    check("full_refill_level", level_o, 32);
    check("full_refill_ready", s_ready_o, 0);

    // Flush wins over a same-cycle write and read; data_o holds
    drive(1'b1, 16'h5555, 1'b1, 1'b1);
    check("flush_level", level_o, 0);
    check("flush_vld", data_vld_o, 0);
    check("flush_data_hold", data_o, 16'h0100);
    check("flush_rdy", data_rdy_o, 0);
    check("flush_ready", s_ready_o, 1);

    // Underflow
    push_words(16'h000A, 3);
    drive(1'b0, 16'h0, 1'b1, 1'b0);
    check("uf_set", underflow_o, 1);
    check("uf_vld", data_vld_o, 0);
    check("uf_level", level_o, 3);
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    check("uf_sticky", underflow_o, 1);
    check("uf_sticky_level", level_o, 3);
    drive(1'b0, 16'h0, 1'b0, 1'b1);
    check("uf_flush_clr", underflow_o, 0);
    check("uf_flush_level", level_o, 0);

    // Reset mid-burst
    push_words(16'h0700, 16);
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    for (int k = 0; k < 7; k++) drive(1'b0, 16'h0, 1'b1, 1'b0);
    check("mb_data7", data_o, 16'h0706);
    check("mb_level", level_o, 9);
    rst_n = 1'b0;
    drive(1'b0, 16'h0, 1'b1, 1'b0);
    check("mb_rst_data", data_o, 0);
    check("mb_rst_vld", data_vld_o, 0);
    check("mb_rst_level", level_o, 0);
    check("mb_rst_ready", s_ready_o, 1);
    check("mb_rst_rdy", data_rdy_o, 0);
    check("mb_rst_uf", underflow_o, 0);
    rst_n = 1'b1;
    drive(1'b0, 16'h0, 1'b1, 1'b0);
    check("mb_noreplay_vld", data_vld_o, 0);
    check("mb_noreplay_uf", underflow_o, 1);
    check("mb_noreplay_data", data_o, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
